// File: rtl/id_ex_stage_pkg.sv
`default_nettype none
// ============================================================================
// Module      : id_ex_stage_pkg
// Description : Shared encodings for the ID/EX stage: FSM states, ALU
//               control codes and the bubble control word.
// Revision    : 1.0 - initial release
// ============================================================================
package id_ex_stage_pkg;

    localparam logic [0:0] c_ST_RUN   = 1'b0;
    localparam logic [0:0] c_ST_HOLD1 = 1'b1;

    localparam logic [3:0] c_ALU_AND = 4'b0000;
    localparam logic [3:0] c_ALU_OR  = 4'b0001;
    localparam logic [3:0] c_ALU_ADD = 4'b0010;
    localparam logic [3:0] c_ALU_SUB = 4'b0110;
    localparam logic [3:0] c_ALU_SLT = 4'b0111;

    typedef struct packed {
        logic       alusrc;
        logic       memread;
        logic       memwrite;
        logic       memtoreg;
        logic       regwrite;
        logic [3:0] aluctrl;
    } ex_ctrl_t;

    // A bubble is an instruction with no side effects anywhere downstream.
    localparam ex_ctrl_t c_BUBBLE_CTRL = '0;

endpackage
`default_nettype wire

// File: rtl/id_ex_stage_hazard.sv
`default_nettype none
// ============================================================================
// Module      : id_ex_hazard
// Description : Combinational load-use / branch-operand hazard decode
//               between the instruction in ID and the one in EX.
// Revision    : 1.0 - initial release
// ============================================================================
module id_ex_hazard #(
    parameter int REG_W = 5
) (
    input  logic [REG_W-1:0] id_rs,
    input  logic [REG_W-1:0] id_rt,
    input  logic             id_regdst,
    input  logic             id_memwrite,
    input  logic             id_beq,
    input  logic             id_bne,
    input  logic [REG_W-1:0] ex_dst,
    input  logic             ex_memread,
    input  logic             ex_regwrite,
    output logic             h_lu,
    output logic             h_ba,
    output logic             h_bl
);

    logic w_uses_rt;
    logic w_br;
    logic w_match;

    assign w_uses_rt = id_regdst | id_memwrite | id_beq | id_bne;
    assign w_br      = id_beq | id_bne;
    // $0 is hard-wired, so a write to it can never be a true dependency.
    assign w_match   = (ex_dst != '0) &&
                       ((ex_dst == id_rs) || (w_uses_rt && (ex_dst == id_rt)));

    assign h_lu = ex_memread & w_match;
    assign h_ba = w_br & ex_regwrite & ~ex_memread & w_match;
    assign h_bl = w_br & ex_memread & w_match;

endmodule
`default_nettype wire

// File: rtl/id_ex_stage.sv
`default_nettype none
// ============================================================================
// Module      : id_ex_stage
// Description : ID/EX pipeline register with hazard stall FSM, bubble
//               insertion and a saturating stall-cycle counter.
// Revision    : 1.0 - initial release
// ============================================================================
module id_ex_stage
    import id_ex_stage_pkg::*;
#(
    parameter int DATA_W = 32,
    parameter int REG_W  = 5,
    parameter int CNT_W  = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [DATA_W-1:0] id_pc4,
    input  logic [DATA_W-1:0] id_rsdata,
    input  logic [DATA_W-1:0] id_rtdata,
    input  logic [DATA_W-1:0] id_imm,
    input  logic [REG_W-1:0]  id_rs,
    input  logic [REG_W-1:0]  id_rt,
    input  logic [REG_W-1:0]  id_rd,
    input  logic              id_regdst,
    input  logic              id_alusrc,
    input  logic              id_memread,
    input  logic              id_memwrite,
    input  logic              id_memtoreg,
    input  logic              id_regwrite,
    input  logic              id_beq,
    input  logic              id_bne,
    input  logic [3:0]        id_aluctrl,
    input  logic              ex_flush,
    output logic [DATA_W-1:0] ex_pc4,
    output logic [DATA_W-1:0] ex_rsdata,
    output logic [DATA_W-1:0] ex_rtdata,
    output logic [DATA_W-1:0] ex_imm,
    output logic [REG_W-1:0]  ex_rs,
    output logic [REG_W-1:0]  ex_rt,
    output logic [REG_W-1:0]  ex_dst,
    output logic              ex_alusrc,
    output logic              ex_memread,
    output logic              ex_memwrite,
    output logic              ex_memtoreg,
    output logic              ex_regwrite,
    output logic [3:0]        ex_aluctrl,
    output logic              stall,
    output logic [CNT_W-1:0]  stall_cycles
);

    localparam logic [CNT_W-1:0] c_CNT_MAX = {CNT_W{1'b1}};

    logic [0:0]       r_state;
    ex_ctrl_t         r_ctrl;
    logic [CNT_W-1:0] r_cnt;
    logic             w_h_lu;
    logic             w_h_ba;
    logic             w_h_bl;
    logic             w_stall;
    logic             w_bubble;

    id_ex_hazard #(.REG_W(REG_W)) u_hazard (
        .id_rs       (id_rs),
        .id_rt       (id_rt),
        .id_regdst   (id_regdst),
        .id_memwrite (id_memwrite),
        .id_beq      (id_beq),
        .id_bne      (id_bne),
        .ex_dst      (ex_dst),
        .ex_memread  (ex_memread),
        .ex_regwrite (ex_regwrite),
        .h_lu        (w_h_lu),
        .h_ba        (w_h_ba),
        .h_bl        (w_h_bl)
    );

    always_comb begin
        w_stall = 1'b0;
        if (ex_flush)
            w_stall = 1'b0;
        else if (r_state == c_ST_HOLD1)
            w_stall = 1'b1;
        else
            w_stall = w_h_bl | w_h_lu | w_h_ba;
    end

    assign w_bubble = ex_flush | w_stall;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state   <= c_ST_RUN;
            r_ctrl    <= c_BUBBLE_CTRL;
            r_cnt     <= '0;
            ex_pc4    <= '0;
            ex_rsdata <= '0;
            ex_rtdata <= '0;
            ex_imm    <= '0;
            ex_rs     <= '0;
            ex_rt     <= '0;
            ex_dst    <= '0;
        end else begin
            ex_pc4    <= id_pc4;
            ex_rsdata <= id_rsdata;
            ex_rtdata <= id_rtdata;
            ex_imm    <= id_imm;
            ex_rs     <= id_rs;
            ex_rt     <= id_rt;
            if (w_bubble) begin
                r_ctrl <= c_BUBBLE_CTRL;
                ex_dst <= '0;
            end else begin
                r_ctrl <= '{alusrc:   id_alusrc,
                            memread:  id_memread,
                            memwrite: id_memwrite,
                            memtoreg: id_memtoreg,
                            regwrite: id_regwrite,
                            aluctrl:  id_aluctrl};
                ex_dst <= id_regdst ? id_rd : id_rt;
            end
            // Branch-on-load needs a second bubble so the load reaches MEM.
            if (!ex_flush && (r_state == c_ST_RUN) && w_h_bl)
                r_state <= c_ST_HOLD1;
            else
                r_state <= c_ST_RUN;
            if (w_stall && (r_cnt != c_CNT_MAX))
                r_cnt <= r_cnt + CNT_W'(1);
        end
    end

    assign ex_alusrc    = r_ctrl.alusrc;
    assign ex_memread   = r_ctrl.memread;
    assign ex_memwrite  = r_ctrl.memwrite;
    assign ex_memtoreg  = r_ctrl.memtoreg;
    assign ex_regwrite  = r_ctrl.regwrite;
    assign ex_aluctrl   = r_ctrl.aluctrl;
    assign stall        = w_stall;
    assign stall_cycles = r_cnt;

endmodule
`default_nettype wire
